// File: rtl/image_stream_proc_if.sv
// Pixel-memory read port and processed-pixel output stream of image_stream_proc.
// The master side is the frame reader; the slave side is memory plus the downstream sink.
`timescale 1ns/1ps
interface image_stream_proc_if #(
    parameter int PPC = 2,
    parameter int AW  = 2
);
    logic              mem_en;
    logic [AW-1:0]     mem_addr;
    logic [24*PPC-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [24*PPC-1:0] out_data;
    logic              out_sol;
    logic              out_eol;
    logic              out_eof;

    modport master (
        output mem_en, mem_addr, out_valid, out_data, out_sol, out_eol, out_eof,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_en, mem_addr, out_valid, out_data, out_sol, out_eol, out_eof,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/image_stream_proc.sv
// Frame reader: VSYNC/HBLANK/LINE timing, word fetches from a synchronous pixel memory,
// runtime point operation, and a 2-entry fall-through output buffer with backpressure.
`timescale 1ns/1ps
module image_stream_proc #(
    parameter int WIDTH          = 540,
    parameter int HEIGHT         = 360,
    parameter int PPC            = 2,
    parameter int START_UP_DELAY = 100,
    parameter int HSYNC_DELAY    = 160,
    parameter bit BOTTOM_UP      = 1'b1,
    parameter int AW             = $clog2(WIDTH*HEIGHT/PPC)
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       start,
    input  logic [1:0]                 mode,
    input  logic                       sign,
    input  logic [7:0]                 value,
    input  logic [7:0]                 threshold,
    image_stream_proc_if.master        bus,
    output logic                       VSYNC,
    output logic                       HSYNC,
    output logic                       busy,
    output logic                       ctrl_done
);
    localparam int WPL  = WIDTH / PPC;
    localparam int CW   = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int DMAX = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
    localparam int DW   = $clog2(DMAX + 1);
    localparam int BW   = 24 * PPC;
    localparam int FW   = BW + 3;

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_HBLANK, S_LINE, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     dcnt_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [1:0]        mode_q;
    logic              sign_q;
    logic [7:0]        value_q;
    logic [7:0]        thr_q;
    logic              done_q;
    logic              vld_p1_q;
    logic [2:0]        flg_p1_q;
    logic [FW-1:0]     fifo_q [2];
    logic              wr_q, rd_q;
    logic [1:0]        cnt_q;

    logic              accept, issue, pop, push, fpop, last_col, last_row, out_vld;
    logic [2:0]        occ;
    logic [RW-1:0]     row_eff;
    logic [AW-1:0]     addr;
    logic [BW-1:0]     proc_p1;
    logic [FW-1:0]     head;

    function automatic logic [7:0] sat_u8(input logic signed [9:0] v);
        if (v < 10'sd0)
            return 8'd0;
        else if (v > 10'sd255)
            return 8'd255;
        return v[7:0];
    endfunction

    function automatic logic [7:0] bright(input logic [7:0] c, input logic add, input logic [7:0] off);
        logic signed [9:0] a, b;
        a = $signed({2'b00, c});
        b = $signed({2'b00, off});
        return sat_u8(add ? a + b : a - b);
    endfunction

    function automatic logic [23:0] proc_pixel(input logic [23:0] px, input logic [1:0] m,
                                               input logic s, input logic [7:0] v,
                                               input logic [7:0] t);
        logic [9:0] sum, gray;
        logic [7:0] lvl;
        sum  = 10'(px[23:16]) + 10'(px[15:8]) + 10'(px[7:0]);
        gray = sum / 10'd3;
        case (m)
            2'd1: return {bright(px[23:16], s, v), bright(px[15:8], s, v), bright(px[7:0], s, v)};
            2'd2: begin
                lvl = sat_u8($signed(10'd255 - gray));
                return {lvl, lvl, lvl};
            end
            2'd3: begin
                lvl = (gray > {2'b00, t}) ? 8'd255 : 8'd0;
                return {lvl, lvl, lvl};
            end
            default: return px;
        endcase
    endfunction

    // Control decode; occupancy counts the beat leaving this cycle so fetches stream back-to-back.
    assign accept   = (state_q == S_IDLE) && start && !done_q;
    assign out_vld  = (cnt_q != 2'd0) || vld_p1_q;
    assign pop      = out_vld && bus.out_ready;
    assign occ      = 3'(cnt_q) + 3'(vld_p1_q) - 3'(pop);
    assign issue    = (state_q == S_LINE) && (occ <= 3'd1);
    assign last_col = (col_q == CW'(WPL - 1));
    assign last_row = (row_q == RW'(HEIGHT - 1));
    assign row_eff  = BOTTOM_UP ? (RW'(HEIGHT - 1) - row_q) : row_q;
    assign addr     = AW'(row_eff) * AW'(WPL) + AW'(col_q);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_VSYNC;
            S_VSYNC:  if (dcnt_q == DW'(START_UP_DELAY - 1)) state_d = S_HBLANK;
            S_HBLANK: if (dcnt_q == DW'(HSYNC_DELAY - 1)) state_d = S_LINE;
            S_LINE:   if (issue && last_col) state_d = last_row ? S_DRAIN : S_HBLANK;
            S_DRAIN:  if (occ == 3'd0) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        VSYNC        = (state_q == S_VSYNC);
        HSYNC        = (state_q == S_LINE);
        busy         = (state_q != S_IDLE);
        bus.mem_en   = issue;
        bus.mem_addr = issue ? addr : '0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dcnt_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            mode_q  <= '0;
            sign_q  <= 1'b0;
            value_q <= '0;
            thr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= (state_q == S_DRAIN) && (state_d == S_IDLE);
            if (state_d != state_q)
                dcnt_q <= '0;
            else if (state_q == S_VSYNC || state_q == S_HBLANK)
                dcnt_q <= dcnt_q + DW'(1);
            if (accept) begin
                col_q   <= '0;
                row_q   <= '0;
                mode_q  <= mode;
                sign_q  <= sign;
                value_q <= value;
                thr_q   <= threshold;
            end else if (issue) begin
                col_q <= last_col ? '0 : col_q + CW'(1);
                if (last_col) row_q <= row_q + RW'(1);
            end
        end
    end

    // Stage p1: read returning from memory, processed in its arrival cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) vld_p1_q <= 1'b0;
        else          vld_p1_q <= issue;
    end

    always_ff @(posedge HCLK) begin
        flg_p1_q <= {col_q == '0, last_col, last_col && last_row};
    end

    always_comb begin
        proc_p1 = '0;
        for (int k = 0; k < PPC; k++)
            proc_p1[24*k +: 24] = proc_pixel(bus.mem_rdata[24*k +: 24], mode_q, sign_q, value_q, thr_q);
    end

    // Output buffer: an arriving beat bypasses straight out when the buffer is empty and taken.
    assign push = vld_p1_q && ((cnt_q != 2'd0) || !bus.out_ready);
    assign fpop = pop && (cnt_q != 2'd0);
    assign head = (cnt_q != 2'd0) ? fifo_q[rd_q] : {flg_p1_q, proc_p1};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 2'(push) - 2'(fpop);
            if (push) wr_q <= ~wr_q;
            if (fpop) rd_q <= ~rd_q;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) fifo_q[wr_q] <= {flg_p1_q, proc_p1};
    end

    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_vld ? head[BW-1:0] : '0;
    assign bus.out_sol   = out_vld && head[FW-1];
    assign bus.out_eol   = out_vld && head[FW-2];
    assign bus.out_eof   = out_vld && head[FW-3];
    assign ctrl_done     = done_q;
endmodule

// File: tb/tb_image_stream_proc.sv
// Directed bench: small bottom-up frame for timing, addressing and point operations,
// plus a top-down PPC=4 frame under random backpressure against a reference model.
`timescale 1ns/1ps
module tb_image_stream_proc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       startA = 1'b0, signA = 1'b0, vsA, hsA, busyA, doneA;
    logic [1:0] modeA = '0;
    logic [7:0] valueA = '0, thrA = '0;
    logic       startB = 1'b0, signB = 1'b0, vsB, hsB, busyB, doneB;
    logic [1:0] modeB = '0;
    logic [7:0] valueB = '0, thrB = '0;

    image_stream_proc_if #(.PPC(2), .AW(2)) ifa ();
    image_stream_proc_if #(.PPC(4), .AW(4)) ifb ();

    image_stream_proc #(.WIDTH(4), .HEIGHT(2), .PPC(2), .START_UP_DELAY(3), .HSYNC_DELAY(2),
                        .BOTTOM_UP(1'b1), .AW(2)) dut_a (
        .HCLK(clk), .HRESETn(rst_n), .start(startA), .mode(modeA), .sign(signA),
        .value(valueA), .threshold(thrA), .bus(ifa), .VSYNC(vsA), .HSYNC(hsA),
        .busy(busyA), .ctrl_done(doneA));

    image_stream_proc #(.WIDTH(16), .HEIGHT(4), .PPC(4), .START_UP_DELAY(4), .HSYNC_DELAY(3),
                        .BOTTOM_UP(1'b0), .AW(4)) dut_b (
        .HCLK(clk), .HRESETn(rst_n), .start(startB), .mode(modeB), .sign(signB),
        .value(valueB), .threshold(thrB), .bus(ifb), .VSYNC(vsB), .HSYNC(hsB),
        .busy(busyB), .ctrl_done(doneB));

    logic [47:0] memA [4];
    logic [95:0] memB [16];
    always @(posedge clk) if (ifa.mem_en) ifa.mem_rdata <= memA[ifa.mem_addr];
    always @(posedge clk) if (ifb.mem_en) ifb.mem_rdata <= memB[ifb.mem_addr];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [23:0] ref_px(input logic [1:0] m, input logic s, input logic [7:0] v,
                                           input logic [7:0] t, input logic [23:0] p);
        int c [3];
        int o [3];
        int gy, vi, ti;
        vi = int'(v);
        ti = int'(t);
        c[0] = int'(p[23:16]);
        c[1] = int'(p[15:8]);
        c[2] = int'(p[7:0]);
        gy = (c[0] + c[1] + c[2]) / 3;
        for (int k = 0; k < 3; k++) begin
            case (m)
                2'd0: o[k] = c[k];
                2'd1: o[k] = s ? ((c[k] + vi > 255) ? 255 : c[k] + vi)
                               : ((c[k] - vi < 0) ? 0 : c[k] - vi);
                2'd2: o[k] = 255 - gy;
                default: o[k] = (gy > ti) ? 255 : 0;
            endcase
        end
        return {o[0][7:0], o[1][7:0], o[2][7:0]};
    endfunction

    // Frame A capture
    logic [50:0] beatsA [$];
    logic [1:0]  addrA [$];
    int vs_cnt, vs_first, en_first, hs_cnt, done_cnt, done_i, last_beat_i;
    logic busy_at_done;

    task automatic run_a(input logic [1:0] m, input logic s, input logic [7:0] v,
                         input logic [7:0] t, input bit disturb);
        beatsA.delete();
        addrA.delete();
        vs_cnt = 0; vs_first = 0; en_first = 0; hs_cnt = 0;
        done_cnt = 0; done_i = 0; last_beat_i = 0; busy_at_done = 1'b1;
        modeA = m; signA = s; valueA = v; thrA = t; startA = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (vsA) begin vs_cnt++; if (vs_first == 0) vs_first = i; end
            if (hsA) hs_cnt++;
            if (ifa.mem_en) begin addrA.push_back(ifa.mem_addr); if (en_first == 0) en_first = i; end
            if (ifa.out_valid && ifa.out_ready) begin
                beatsA.push_back({ifa.out_sol, ifa.out_eol, ifa.out_eof, ifa.out_data});
                last_beat_i = i;
            end
            if (doneA) begin done_cnt++; done_i = i; busy_at_done = busyA; end
            startA = 1'b0;
            if (disturb) begin
                if (i == 5) begin startA = 1'b1; modeA = 2'd2; valueA = 8'd77; end
                if (doneA) startA = 1'b1;
            end
        end
        startA = 1'b0;
    endtask

    task automatic fill_a_pass();
        memA[0] = 48'h111111_222222;
        memA[1] = 48'h333333_444444;
        memA[2] = 48'h555555_666666;
        memA[3] = 48'h777777_888888;
    endtask

    task automatic check_pass_beats(input string tag);
        logic [1:0] ea [4];
        logic [2:0] ef [4];
        ea = '{2'd2, 2'd3, 2'd0, 2'd1};
        ef = '{3'b100, 3'b010, 3'b100, 3'b011};
        chk({tag, "_nbeats"}, beatsA.size(), 4);
        for (int j = 0; j < 4; j++)
            chk($sformatf("%s_beat%0d", tag, j), (j < beatsA.size()) ? beatsA[j] : 51'h0,
                {ef[j], memA[ea[j]]});
    endtask

    typedef struct {
        logic [1:0]  m;
        logic        s;
        logic [7:0]  v;
        logic [7:0]  t;
        logic [23:0] px;
        logic [23:0] ex;
    } vec_t;
    vec_t vt [8];

    logic [98:0] expB [16];

    initial begin
        logic       found;
        logic       prev_stall;
        logic [98:0] prev_word, gotB;
        int nb, doneB_cnt, k_done;
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ctrl_a", {vsA, hsA, busyA, doneA, ifa.mem_en, ifa.out_valid}, 6'b0);
        chk("rst_bus_a", {ifa.mem_addr, ifa.out_data, ifa.out_sol, ifa.out_eol, ifa.out_eof}, 0);
        chk("rst_ctrl_b", {vsB, hsB, busyB, doneB, ifb.mem_en, ifb.out_valid}, 6'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", {busyA, busyB, ifa.out_valid, ifb.out_valid}, 4'b0);

        // Pass frame: timing, bottom-up addressing, flags, done pulse
        fill_a_pass();
        run_a(2'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        chk("vsync_first", vs_first, 1);
        chk("vsync_len", vs_cnt, 3);
        chk("first_mem_en", en_first, 6);
        chk("hsync_cycles", hs_cnt, 4);
        chk("addr_count", addrA.size(), 4);
        chk("addr_seq", (addrA.size() == 4) ? {addrA[0], addrA[1], addrA[2], addrA[3]} : 8'h0,
            {2'd2, 2'd3, 2'd0, 2'd1});
        check_pass_beats("pass");
        chk("done_once", done_cnt, 1);
        chk("done_after_last_beat", done_i - last_beat_i, 1);
        chk("busy_low_at_done", busy_at_done, 1'b0);

        // Point operations
        vt[0] = '{2'd1, 1'b1, 8'd100, 8'd0,  {8'd200, 8'd50, 8'd155}, {8'd255, 8'd150, 8'd255}};
        vt[1] = '{2'd1, 1'b0, 8'd100, 8'd0,  {8'd30, 8'd100, 8'd101}, {8'd0, 8'd0, 8'd1}};
        vt[2] = '{2'd2, 1'b0, 8'd0,   8'd0,  {8'd10, 8'd20, 8'd30},   {8'd235, 8'd235, 8'd235}};
        vt[3] = '{2'd2, 1'b0, 8'd0,   8'd0,  {8'd255, 8'd255, 8'd254}, {8'd1, 8'd1, 8'd1}};
        vt[4] = '{2'd3, 1'b0, 8'd0,   8'd90, {8'd91, 8'd91, 8'd91},   {8'd255, 8'd255, 8'd255}};
        vt[5] = '{2'd3, 1'b0, 8'd0,   8'd90, {8'd90, 8'd90, 8'd90},   {8'd0, 8'd0, 8'd0}};
        vt[6] = '{2'd3, 1'b0, 8'd0,   8'd90, {8'd92, 8'd90, 8'd89},   {8'd0, 8'd0, 8'd0}};
        vt[7] = '{2'd0, 1'b0, 8'd0,   8'd0,  {8'd12, 8'd34, 8'd56},   {8'd12, 8'd34, 8'd56}};
        for (int i = 0; i < 8; i++) begin
            for (int w = 0; w < 4; w++) memA[w] = {vt[i].px, vt[i].px};
            run_a(vt[i].m, vt[i].s, vt[i].v, vt[i].t, 1'b0);
            chk($sformatf("op%0d_beats", i), beatsA.size(), 4);
            chk($sformatf("op%0d_pixel", i), (beatsA.size() > 0) ? beatsA[0][47:0] : 48'h0,
                {vt[i].ex, vt[i].ex});
        end

        // start and mode changes mid-frame, start coinciding with ctrl_done
        fill_a_pass();
        run_a(2'd0, 1'b0, 8'd0, 8'd0, 1'b1);
        chk("dist_vsync_len", vs_cnt, 3);
        chk("dist_done_once", done_cnt, 1);
        check_pass_beats("dist");

        // Reset in the middle of LINE
        modeA = 2'd0;
        startA = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            startA = 1'b0;
            if (hsA && ifa.out_valid) found = 1'b1;
        end
        chk("midline_reached", found, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctrl", {vsA, hsA, busyA, doneA, ifa.mem_en, ifa.out_valid}, 6'b0);
        chk("midrst_bus", {ifa.mem_addr, ifa.out_data, ifa.out_sol, ifa.out_eol, ifa.out_eof}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_idle", busyA, 1'b0);
        run_a(2'd0, 1'b0, 8'd0, 8'd0, 1'b0);
        chk("post_rst_done", done_cnt, 1);
        check_pass_beats("postrst");

        // PPC=4 top-down frame, brightness add 40, random backpressure
        for (int i = 0; i < 16; i++) memB[i] = {$urandom(), $urandom(), $urandom()};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                expB[r*4+c][98] = (c == 0);
                expB[r*4+c][97] = (c == 3);
                expB[r*4+c][96] = (r == 3) && (c == 3);
                for (int p = 0; p < 4; p++)
                    expB[r*4+c][24*p +: 24] = ref_px(2'd1, 1'b1, 8'd40, 8'd0, memB[r*4+c][24*p +: 24]);
            end
        modeB = 2'd1; signB = 1'b1; valueB = 8'd40; thrB = 8'd0; startB = 1'b1;
        nb = 0; doneB_cnt = 0; k_done = 0; prev_stall = 1'b0; prev_word = '0;
        for (int i = 1; i <= 800; i++) begin
            @(negedge clk);
            startB = (i == 30);
            if (i == 30) modeB = 2'd3;
            ifb.out_ready = 1'($urandom_range(0, 1));
            #1;
            gotB = {ifb.out_sol, ifb.out_eol, ifb.out_eof, ifb.out_data};
            if (prev_stall) begin
                chk("hold_valid", ifb.out_valid, 1'b1);
                chk("hold_data", gotB, prev_word);
            end
            if (ifb.out_valid && ifb.out_ready) begin
                if (nb < 16) chk($sformatf("B_beat%0d", nb), gotB, expB[nb]);
                else         chk("B_beat_count_limit", nb, 15);
                nb++;
            end
            prev_stall = ifb.out_valid && !ifb.out_ready;
            prev_word  = gotB;
            if (doneB) doneB_cnt++;
            if (doneB_cnt > 0) k_done++;
            if (k_done > 4) break;
        end
        chk("B_beats", nb, 16);
        chk("B_done_once", doneB_cnt, 1);
        chk("B_idle_end", busyB, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
